// File: rtl/bound_flasher_param.sv
// Parametrised bound flasher: sweeps a thermometer lamp bar up and down through six phases,
// with flick-driven kickback at two bound points, a step prescaler and optional auto-repeat.
module bound_flasher_param #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned UP1_TGT  = 6,
    parameter int unsigned UP2_TGT  = 11,
    parameter int unsigned DN2_TGT  = 5,
    parameter int unsigned KB1      = 6,
    parameter int unsigned KB2      = 11,
    parameter int unsigned STEP_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flick,
    input  logic             loop,
    output logic [WIDTH-1:0] lamp,
    output logic             busy,
    output logic             done,
    output logic [2:0]       phase
);

    localparam int unsigned LW = $clog2(WIDTH + 1);
    localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [LW-1:0] UP1_L   = LW'(UP1_TGT);
    localparam logic [LW-1:0] UP2_L   = LW'(UP2_TGT);
    localparam logic [LW-1:0] DN2_L   = LW'(DN2_TGT);
    localparam logic [LW-1:0] KB1_L   = LW'(KB1);
    localparam logic [LW-1:0] KB2_L   = LW'(KB2);
    localparam logic [LW-1:0] FULL_L  = LW'(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(STEP_DIV - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP1  = 3'd1,
        DN1  = 3'd2,
        UP2  = 3'd3,
        DN2  = 3'd4,
        UP3  = 3'd5,
        DN3  = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    l_q, l_d;
    logic [LW-1:0]    l_step;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] lamp_q, lamp_d;
    logic             tick;

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            UP1, UP2, UP3: l_step = l_q + LW'(1);
            DN1, DN2, DN3: l_step = l_q - LW'(1);
            default:       l_step = l_q;
        endcase

        if (state_q == IDLE) begin
            cnt_d = '0;
            l_d   = '0;
            if (flick) begin
                state_d = UP1;
            end
        end else begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
                l_d = l_step;
                // Transitions compare against the post-step count so the state change lands
                // on the same edge as the lamp update; kickback outranks the sweep target.
                case (state_q)
                    UP1: if (l_step == UP1_L) state_d = DN1;
                    DN1: if (l_step == '0)    state_d = UP2;
                    UP2: begin
                        if (flick && (l_step == KB1_L))  state_d = DN1;
                        else if (l_step == UP2_L)        state_d = DN2;
                    end
                    DN2: if (l_step == DN2_L) state_d = UP3;
                    UP3: begin
                        if (flick && (l_step == KB2_L))  state_d = DN2;
                        else if (l_step == FULL_L)       state_d = DN3;
                    end
                    DN3: begin
                        if (l_step == '0) begin
                            state_d = loop ? UP1 : IDLE;
                            done_d  = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        busy_d = (state_d != IDLE);

        lamp_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            lamp_d[i] = (i < 32'(l_d));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            l_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            lamp_q  <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            lamp_q  <= lamp_d;
        end
    end

    assign lamp  = lamp_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign phase = state_q;

endmodule

// File: tb/tb_bound_flasher_param.sv
// Directed vector bench for bound_flasher_param across four parameter sets.
module tb_bound_flasher_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i   [4];
    logic flick_i [4];
    logic loop_i  [4];

    logic [15:0] lamp_a, lamp_b;
    logic [7:0]  lamp_c;
    logic [3:0]  lamp_d;
    logic [2:0]  phase_o [4];
    logic        busy_o  [4];
    logic        done_o  [4];

    bound_flasher_param dut_a (
        .clk(clk), .rst(rst_i[0]), .flick(flick_i[0]), .loop(loop_i[0]),
        .lamp(lamp_a), .busy(busy_o[0]), .done(done_o[0]), .phase(phase_o[0])
    );

    bound_flasher_param #(.STEP_DIV(3)) dut_b (
        .clk(clk), .rst(rst_i[1]), .flick(flick_i[1]), .loop(loop_i[1]),
        .lamp(lamp_b), .busy(busy_o[1]), .done(done_o[1]), .phase(phase_o[1])
    );

    bound_flasher_param #(
        .WIDTH(8), .UP1_TGT(3), .UP2_TGT(6), .DN2_TGT(2), .KB1(3), .KB2(6), .STEP_DIV(1)
    ) dut_c (
        .clk(clk), .rst(rst_i[2]), .flick(flick_i[2]), .loop(loop_i[2]),
        .lamp(lamp_c), .busy(busy_o[2]), .done(done_o[2]), .phase(phase_o[2])
    );

    bound_flasher_param #(
        .WIDTH(4), .UP1_TGT(2), .UP2_TGT(3), .DN2_TGT(1), .KB1(3), .KB2(4), .STEP_DIV(1)
    ) dut_d (
        .clk(clk), .rst(rst_i[3]), .flick(flick_i[3]), .loop(loop_i[3]),
        .lamp(lamp_d), .busy(busy_o[3]), .done(done_o[3]), .phase(phase_o[3])
    );

    typedef struct {
        int    sel;
        bit    rst;
        bit    fl;
        bit    lp;
        int    l;
        int    ph;
        bit    done;
        string nm;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input int s, input bit r, input bit fl, input bit lp,
                       input int l, input int ph, input bit dn, input string nm);
        vec_t v;
        v.sel = s; v.rst = r; v.fl = fl; v.lp = lp;
        v.l = l; v.ph = ph; v.done = dn; v.nm = nm;
        vq.push_back(v);
    endtask

    // One sweep from 'from' to 'to'; each step holds div-1 edges, the final step changes phase.
    task automatic sweep(input int s, input int from, input int to, input int cur, input int nxt,
                         input bit fl, input bit lp, input int div, input bit fin_done,
                         input string nm);
        int v;
        v = from;
        while (v != to) begin
            for (int k = 0; k < div - 1; k++) add(s, 0, fl, lp, v, cur, 0, nm);
            v = (to > from) ? v + 1 : v - 1;
            add(s, 0, fl, lp, v, (v == to) ? nxt : cur, (v == to) && fin_done, nm);
        end
    endtask

    task automatic full_run(input int s, input bit lp, input int div, input int last_ph,
                            input string nm);
        sweep(s, 0, 6, 1, 2, 0, lp, div, 0, nm);
        sweep(s, 6, 0, 2, 3, 0, lp, div, 0, nm);
        sweep(s, 0, 11, 3, 4, 0, lp, div, 0, nm);
        sweep(s, 11, 5, 4, 5, 0, lp, div, 0, nm);
        sweep(s, 5, 16, 5, 6, 0, lp, div, 0, nm);
        sweep(s, 16, 0, 6, last_ph, 0, lp, div, 1, nm);
    endtask

    task automatic chk(input string nm, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h exp=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic check_out(input int s, input int l, input int ph, input bit dn,
                             input string nm, input int idx);
        logic [63:0] exp_lamp, act_lamp;
        exp_lamp = '0;
        for (int k = 0; k < l; k++) exp_lamp[k] = 1'b1;
        case (s)
            0:       act_lamp = 64'(lamp_a);
            1:       act_lamp = 64'(lamp_b);
            2:       act_lamp = 64'(lamp_c);
            default: act_lamp = 64'(lamp_d);
        endcase
        chk({nm, "_lamp"},  idx, act_lamp, exp_lamp);
        chk({nm, "_phase"}, idx, 64'(phase_o[s]), 64'(ph));
        chk({nm, "_busy"},  idx, 64'(busy_o[s]), 64'(ph != 0));
        chk({nm, "_done"},  idx, 64'(done_o[s]), 64'(dn));
    endtask

    task automatic drive_idle();
        for (int s = 0; s < 4; s++) begin
            rst_i[s] = 1'b0; flick_i[s] = 1'b0; loop_i[s] = 1'b0;
        end
    endtask

    initial begin
        for (int s = 0; s < 4; s++) begin
            rst_i[s] = 1'b1; flick_i[s] = 1'b0; loop_i[s] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;

        // Default parameters: plain pass, 56 steps
        add(0, 1, 0, 0, 0, 0, 0, "a_rst");
        add(0, 0, 1, 0, 0, 1, 0, "a_start");
        full_run(0, 0, 1, 0, "a_seq");
        add(0, 0, 0, 0, 0, 0, 0, "a_idle");

        // Flick held: kickback at KB1 twice, released at edge 30, KB2 then skipped
        add(0, 0, 1, 0, 0, 1, 0, "a_kstart");
        sweep(0, 0, 6, 1, 2, 1, 0, 1, 0, "a_kb");
        sweep(0, 6, 0, 2, 3, 1, 0, 1, 0, "a_kb");
        sweep(0, 0, 6, 3, 2, 1, 0, 1, 0, "a_kb");
        sweep(0, 6, 0, 2, 3, 1, 0, 1, 0, "a_kb");
        sweep(0, 0, 5, 3, 3, 1, 0, 1, 0, "a_kb");
        sweep(0, 5, 11, 3, 4, 0, 0, 1, 0, "a_kb");
        sweep(0, 11, 5, 4, 5, 0, 0, 1, 0, "a_kb");
        sweep(0, 5, 16, 5, 6, 0, 0, 1, 0, "a_kb");
        sweep(0, 16, 0, 6, 0, 0, 0, 1, 1, "a_kb");
        // Flick on the first IDLE edge restarts immediately
        add(0, 0, 1, 0, 0, 1, 0, "a_restart");

        // Reset mid-UP2 at L=9 with a same-edge flick
        sweep(0, 0, 6, 1, 2, 0, 0, 1, 0, "a_pre");
        sweep(0, 6, 0, 2, 3, 0, 0, 1, 0, "a_pre");
        sweep(0, 0, 9, 3, 3, 0, 0, 1, 0, "a_pre");
        add(0, 1, 1, 0, 0, 0, 0, "a_midrst");
        add(0, 0, 0, 0, 0, 0, 0, "a_postrst");
        add(0, 0, 1, 1, 0, 1, 0, "a_lstart");

        // Loop: DN3 wraps straight into UP1, then a final pass with loop low
        full_run(0, 1, 1, 1, "a_loop1");
        full_run(0, 0, 1, 0, "a_loop2");
        add(0, 0, 0, 0, 0, 0, 0, "a_lidle");

        // STEP_DIV=3: 168-edge pass
        add(1, 1, 0, 0, 0, 0, 0, "b_rst");
        add(1, 0, 1, 0, 0, 1, 0, "b_start");
        full_run(1, 0, 3, 0, "b_seq");
        add(1, 0, 0, 0, 0, 0, 0, "b_idle");

        // WIDTH=8: repeated kickback at both bound points
        add(2, 1, 0, 0, 0, 0, 0, "c_rst");
        add(2, 0, 1, 0, 0, 1, 0, "c_start");
        sweep(2, 0, 3, 1, 2, 1, 0, 1, 0, "c_seq");
        sweep(2, 3, 0, 2, 3, 1, 0, 1, 0, "c_seq");
        sweep(2, 0, 3, 3, 2, 1, 0, 1, 0, "c_seq");
        sweep(2, 3, 0, 2, 3, 1, 0, 1, 0, "c_seq");
        sweep(2, 0, 3, 3, 2, 1, 0, 1, 0, "c_seq");
        sweep(2, 3, 0, 2, 3, 0, 0, 1, 0, "c_seq");
        sweep(2, 0, 6, 3, 4, 0, 0, 1, 0, "c_seq");
        sweep(2, 6, 2, 4, 5, 1, 0, 1, 0, "c_seq");
        sweep(2, 2, 6, 5, 4, 1, 0, 1, 0, "c_seq");
        sweep(2, 6, 2, 4, 5, 1, 0, 1, 0, "c_seq");
        sweep(2, 2, 6, 5, 4, 1, 0, 1, 0, "c_seq");
        sweep(2, 6, 2, 4, 5, 0, 0, 1, 0, "c_seq");
        sweep(2, 2, 8, 5, 6, 0, 0, 1, 0, "c_seq");
        sweep(2, 8, 0, 6, 0, 0, 0, 1, 1, "c_seq");
        add(2, 0, 0, 0, 0, 0, 0, "c_idle");

        // WIDTH=4: kickback points coincide with UP2 target and full bar
        add(3, 1, 0, 0, 0, 0, 0, "d_rst");
        add(3, 0, 1, 0, 0, 1, 0, "d_start");
        sweep(3, 0, 2, 1, 2, 1, 0, 1, 0, "d_seq");
        sweep(3, 2, 0, 2, 3, 1, 0, 1, 0, "d_seq");
        sweep(3, 0, 3, 3, 2, 1, 0, 1, 0, "d_seq");
        sweep(3, 3, 0, 2, 3, 0, 0, 1, 0, "d_seq");
        sweep(3, 0, 3, 3, 4, 0, 0, 1, 0, "d_seq");
        sweep(3, 3, 1, 4, 5, 1, 0, 1, 0, "d_seq");
        sweep(3, 1, 4, 5, 4, 1, 0, 1, 0, "d_seq");
        sweep(3, 4, 1, 4, 5, 0, 0, 1, 0, "d_seq");
        sweep(3, 1, 4, 5, 6, 0, 0, 1, 0, "d_seq");
        sweep(3, 4, 0, 6, 0, 0, 0, 1, 1, "d_seq");
        add(3, 0, 0, 0, 0, 0, 0, "d_idle");

        for (int i = 0; i < vq.size(); i++) begin
            drive_idle();
            rst_i[vq[i].sel]   = vq[i].rst;
            flick_i[vq[i].sel] = vq[i].fl;
            loop_i[vq[i].sel]  = vq[i].lp;
            @(posedge clk);
            #1;
            check_out(vq[i].sel, vq[i].l, vq[i].ph, vq[i].done, vq[i].nm, i);
        end

        // Prescaler mid-count reset, then restart timing from a cleared count
        drive_idle();
        flick_i[1] = 1'b1;
        @(posedge clk); #1;
        flick_i[1] = 1'b0;
        check_out(1, 0, 1, 0, "b_hs_start", 0);
        repeat (4) @(posedge clk);
        #1;
        check_out(1, 1, 1, 0, "b_hs_step", 1);
        rst_i[1] = 1'b1;
        @(posedge clk); #1;
        rst_i[1] = 1'b0;
        check_out(1, 0, 0, 0, "b_hs_rst", 2);
        flick_i[1] = 1'b1;
        @(posedge clk); #1;
        flick_i[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out(1, 0, 1, 0, "b_hs_hold", 3);
        @(posedge clk); #1;
        check_out(1, 1, 1, 0, "b_hs_first", 4);
        rst_i[1] = 1'b1;
        @(posedge clk); #1;
        rst_i[1] = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bound_flasher_param.md
# bound_flasher_param

Parametrised successor to the 16-lamp bound flasher. It drives a thermometer-coded lamp bar through a fixed sequence of up and down sweeps. Kickback is taken at two configurable bound points while `flick` is held. New in this generation: configurable bar width and bound points, a step prescaler, auto-repeat (`loop`), and status outputs (`busy`, `done`, `phase`). It sits directly behind the lamp driver and is started by the same `flick` control as before.

## Interface
- `WIDTH`, 16: number of lamps, legal range 4..64.
- `UP1_TGT`, 6: lit count at the end of the first up sweep.
- `UP2_TGT`, 11: lit count at the end of the second up sweep.
- `DN2_TGT`, 5: lit count at the end of the second down sweep.
- `KB1`, 6: kickback point in the second up sweep; must satisfy 0 < KB1 <= UP2_TGT.
- `KB2`, 11: kickback point in the third up sweep; must satisfy DN2_TGT < KB2 <= WIDTH.
- `STEP_DIV`, 1: clock cycles per lamp step, at least 1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flick` in 1: start request in IDLE; kickback request at KB1/KB2.
- `loop` in 1: when 1 at the end of the sequence, restart without needing `flick`.
- `lamp` out WIDTH: thermometer bar; bits [L-1:0] are 1, where L is the lit count.
- `busy` out 1: 1 whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when the sequence completes.
- `phase` out 3: state code.

## Operation
- Internal lit count `L` is `$clog2(WIDTH+1)` bits wide. `lamp = (1<<L)-1`, registered.
- State codes: IDLE=0, UP1=1, DN1=2, UP2=3, DN2=4, UP3=5, DN3=6.
- Prescaler `cnt` runs 0..STEP_DIV-1 and is held at 0 in IDLE. A tick occurs when `cnt==STEP_DIV-1`.
- IDLE: `L=0`. With `flick=1` at an edge, go to UP1 with `cnt` cleared and `L` unchanged.
- On each tick in an UP state, `L<=L+1`. On each tick in a DN state, `L<=L-1`.
- Normal transitions occur on the tick where the new `L` equals the target:
  - UP1 reaches UP1_TGT -> DN1
  - DN1 reaches 0 -> UP2
  - UP2 reaches UP2_TGT -> DN2
  - DN2 reaches DN2_TGT -> UP3
  - UP3 reaches WIDTH -> DN3
  - DN3 reaches 0 -> UP1 if `loop=1`, else IDLE. `done=1` on the following cycle in either case.
- Kickback: in UP2, on the tick where the new `L` equals KB1 and `flick=1`, go to DN1. In UP3, on the tick where the new `L` equals KB2 and `flick=1`, go to DN2.
- Kickback takes priority over the normal target transition when KB equals the target.
- Kickback repeats for as long as `flick` remains 1 at the kickback point.
- `flick` is ignored at all other times outside IDLE.
- `loop` is sampled only at the end of DN3.

## Timing
- Reset: `lamp=0`, `L=0`, state IDLE, `phase=0`, `busy=0`, `done=0`, `cnt=0`.
  - Reset applies at any point mid-sequence and overrides all other events on that edge, including a same-edge `flick`.
- Start latency: the `flick` edge moves the state to UP1. The first lamp lights STEP_DIV edges later.
- Default parameters, STEP_DIV=1, no kickback: 6+6+11+6+11+16 = 56 steps.
  - Counting the start edge as edge 0, `L` returns to 0 at edge 56 and `done` is high for the cycle after edge 56.
- `busy` rises on the start edge and falls on the edge where DN3 reaches 0 with `loop=0`.
  - With `loop=1`, `busy` stays 1 continuously.
- Only one `L` step per tick. A state change takes effect on the same edge as the `L` update that triggered it.
- `flick` held through IDLE while `busy=0` restarts on the edge immediately after returning to IDLE.

## Test plan
- Default params, one-cycle `flick` pulse -> `L` goes 0→6→0→11→5→16→0 in 56 edges; `done` pulses once; `busy=0` afterwards.
- `flick` held high from the start, released at edge 30 -> kickback at `L=6` in UP2 back to 0, repeated while held; after release the sequence proceeds, and KB2 at `L=11` is not taken; `done` follows.
- `rst=1` for one cycle when `L=9` in UP2 -> next cycle `lamp=0`, `phase=0`, `busy=0`; a later `flick` restarts from UP1.
- `loop=1` -> at the end of DN3, `phase` goes 6→1 with no idle cycle; `done` pulses each pass; `busy` stays 1.
- STEP_DIV=3 -> each `L` step exactly 3 cycles apart; full sequence in 168 edges.
- WIDTH=8, UP1_TGT=3, UP2_TGT=6, DN2_TGT=2, KB1=3, KB2=6, `flick` held -> kickback at both points, and `lamp` never exceeds 8'hFF.
